// File: rtl/shift_seq_ctrl.sv
// Iterative shifter for the execute stage: SLL/SRL/SRA/ROTR done STEP bits per cycle,
// with the result held until the consumer takes it. Supports pipeline flush.
`timescale 1ns/1ps

module shift_seq_ctrl #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and ready never depends on the same-side valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] STEP_C = 5'(STEP);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [4:0]  cnt_nxt;
  logic [31:0] result_nxt;
  logic [1:0]  op_q;
  logic        sign_q;
  logic        load;
  logic [4:0]  k;
  logic [31:0] shifted;
  logic [63:0] wide;

  // One partial shift of k = min(cnt, STEP) positions on the held result.
  always_comb begin
    k       = (cnt < STEP_C) ? cnt : STEP_C;
    wide    = '0;
    shifted = result;
    case (op_q)
      OP_SLL: shifted = result << k;
      OP_SRL: shifted = result >> k;
      OP_SRA: begin
        wide    = {{32{sign_q}}, result} >> k;
        shifted = wide[31:0];
      end
      default: begin
        wide    = {result, result} >> k;
        shifted = wide[31:0];
      end
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    result_nxt = result;
    load       = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            load       = 1'b1;
            result_nxt = a;
            cnt_nxt    = shamt;
            state_nxt  = (shamt == 5'd0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          result_nxt = shifted;
          cnt_nxt    = cnt - k;
          if (cnt <= STEP_C) state_nxt = DONE;
        end
        DONE: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
      if (load) begin
        op_q   <= op;
        sign_q <= a[31];
      end
    end
  end

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: STEP=1 and STEP=4 instances, directed plan cases plus random
// operations checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid [2];
  logic        out_ready [2];
  logic [1:0]  op [2];
  logic [31:0] a [2];
  logic [4:0]  shamt [2];
  logic        in_ready [2];
  logic        out_valid [2];
  logic        busy [2];
  logic [31:0] result [2];
  logic [1:0]  state_dbg [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op(op[0]), .a(a[0]), .shamt(shamt[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(result[0]), .busy(busy[0]), .state_dbg(state_dbg[0])
  );

  shift_seq_ctrl #(.STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op(op[1]), .a(a[1]), .shamt(shamt[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(result[1]), .busy(busy[1]), .state_dbg(state_dbg[1])
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v,
                                            input logic [4:0] s);
    int sh;
    sh = int'(s);
    case (o)
      2'b00:   return v << sh;
      2'b01:   return v >> sh;
      2'b10:   return 32'($signed(v) >>> sh);
      default: return (sh == 0) ? v : ((v >> sh) | (v << (32 - sh)));
    endcase
  endfunction

  function automatic int lat_of(input int d, input int s);
    int st;
    st = (d == 0) ? 1 : 4;
    return 1 + (s + st - 1) / st;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic accept(input int d, input logic [1:0] o, input logic [31:0] av,
                        input logic [4:0] sh);
    @(negedge clk);
    #1;
    chk("in_ready_idle", 32'(in_ready[d]), 32'd1);
    op[d] = o; a[d] = av; shamt[d] = sh; in_valid[d] = 1'b1;
    exp_q.push_back(ref_shift(o, av, sh));
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    op[d]       = 2'($urandom);
    a[d]        = $urandom;
    shamt[d]    = 5'($urandom);
  endtask

  task automatic wait_done(input int d, input int lat);
    int          edges;
    logic        bz;
    logic [31:0] expv;
    edges = 1;
    bz    = busy[d];
    while (!out_valid[d] && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      bz = bz & busy[d];
    end
    chk("latency", 32'(edges), 32'(lat));
    chk("busy_throughout", 32'(bz), 32'd1);
    chk("out_valid_done", 32'(out_valid[d]), 32'd1);
    expv = exp_q.pop_front();
    chk("result", result[d], expv);
  endtask

  task automatic release_out(input int d, input int hold);
    logic [31:0] r;
    r = result[d];
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid[d]), 32'd1);
      chk("hold_result", result[d], r);
    end
    @(negedge clk);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    chk("valid_drop", 32'(out_valid[d]), 32'd0);
    chk("busy_idle", 32'(busy[d]), 32'd0);
    chk("ready_idle", 32'(in_ready[d]), 32'd1);
  endtask

  task automatic run_op(input int d, input logic [1:0] o, input logic [31:0] av,
                        input logic [4:0] sh, input int hold);
    accept(d, o, av, sh);
    wait_done(d, lat_of(d, int'(sh)));
    release_out(d, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] av;
    logic [31:0] r;
    logic        seen;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      op[d] = '0; a[d] = '0; shamt[d] = '0;
    end

    // Reset state
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_result", result[d], 32'd0);
      chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed plan cases
    run_op(0, 2'b00, 32'h0000_0001, 5'd31, 2);
    for (int d = 0; d < 2; d++) begin
      run_op(d, 2'b10, 32'h8000_0000, 5'd4, 1);
      run_op(d, 2'b01, 32'h8000_0000, 5'd4, 0);
      run_op(d, 2'b00, 32'h8000_0000, 5'd4, 0);
      run_op(d, 2'b11, 32'h0000_00F1, 5'd4, 1);
      run_op(d, 2'b11, 32'hDEAD_BEEF, 5'd0, 0);
    end
    run_op(1, 2'b10, 32'hF000_0000, 5'd7, 0);
    run_op(1, 2'b11, 32'h1234_5678, 5'd31, 0);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    // Backpressure with a pending request held on in_valid
    accept(0, 2'b10, 32'h8000_0000, 5'd4);
    wait_done(0, lat_of(0, 4));
    @(negedge clk);
    in_valid[0] = 1'b1; op[0] = 2'b00; a[0] = 32'h1234_5678; shamt[0] = 5'd3;
    r = result[0];
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_result", result[0], r);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    exp_q.push_back(ref_shift(2'b00, 32'h1234_5678, 5'd3));
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    chk("bp_valid_drop", 32'(out_valid[0]), 32'd0);
    chk("bp_busy_idle", 32'(busy[0]), 32'd0);
    chk("bp_ready_idle", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_done(0, lat_of(0, 3));
    release_out(0, 0);

    // Flush mid-shift
    av = $urandom;
    accept(0, 2'b00, av, 5'd20);
    void'(exp_q.pop_front());
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    chk("flush_busy", 32'(busy[0]), 32'd0);
    chk("flush_result_kept", result[0], av << 4);
    chk("flush_ready_back", 32'(in_ready[0]), 32'd1);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid[0];
    end
    chk("flush_no_valid", 32'(seen), 32'd0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    flush = 1'b1; in_valid[0] = 1'b1; op[0] = 2'b01; a[0] = $urandom; shamt[0] = 5'd5;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid[0] = 1'b0;
    chk("flush_idle_busy", 32'(busy[0]), 32'd0);

    // Asynchronous reset mid-shift
    accept(0, 2'b00, $urandom | 32'h1, 5'd20);
    void'(exp_q.pop_front());
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_result", result[d], 32'd0);
      chk("arst_busy", 32'(busy[d]), 32'd0);
      chk("arst_out_valid", 32'(out_valid[d]), 32'd0);
      chk("arst_in_ready", 32'(in_ready[d]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 2'b11, 32'hCAFE_F00D, 5'd9, 1);
    run_op(1, 2'b10, 32'h8765_4321, 5'd13, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Iterative shift-unit sequencer for the 32-bit CPU execute stage. It accepts one shift operation at a time (SLL/SRL/SRA/ROTR, 5-bit shift amount) over a valid/ready handshake. It performs the shift over multiple cycles, at most STEP bit positions per cycle, then holds the result until the consumer takes it. It replaces a full barrel shifter where area matters and supports pipeline flush.

## Interface
- STEP, 1, max bit positions shifted per cycle; legal values 1, 2, 4, 8.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any in-flight operation
- in_valid  input  1  operation request
- in_ready  output  1  block can accept (high only in IDLE and flush low)
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR
- a  input  32  operand
- shamt  input  5  shift amount, 0..31 unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  32  shifted value, registered
- busy  output  1  high in SHIFT or DONE

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset (rst_n low, any time, any state):
  - state IDLE, result 0, remaining count 0, out_valid 0, busy 0.
  - in_ready 1 once flush is low.
- Accept: in_valid & in_ready at a rising edge.
  - Latch a into result, op into op_q, shamt into cnt.
  - Latch a[31] as sign fill for SRA.
  - Next state is DONE if shamt==0, else SHIFT.
- SHIFT, each edge:
  - k = min(cnt, STEP); result shifted by k according to op_q; cnt <= cnt - k.
  - If cnt <= STEP, next state DONE.
- Shift rules:
  - SLL fills with 0 at the LSBs.
  - SRL fills with 0 at the MSBs.
  - SRA fills the MSBs with the latched sign.
  - ROTR moves bits shifted out of the LSB into the MSB.
  - Widths are always 32-bit; no bits beyond 31 are kept.
- DONE: out_valid=1, result stable.
  - On out_ready, next state is IDLE; out_valid drops the cycle after the handshake.
  - No new accept happens in the same cycle.
- in_ready = (state==IDLE) & ~flush. While not in IDLE, in_valid is ignored and has no side effect.
- flush (sampled at edge, priority over all except reset):
  - Next state IDLE, cnt 0, out_valid 0.
  - result keeps its last value.
  - In DONE, flush wins over out_ready.
  - In IDLE, flush blocks acceptance.
- op or shamt changing after acceptance has no effect.

## Timing
- Latency, from accept edge to first cycle with out_valid high: 1 + ceil(shamt/STEP) edges.
  - shamt=0: out_valid high the cycle after accept.
  - STEP=1, shamt=31: 32 edges.
  - STEP=4, shamt=7: 3 edges (shifts of 4 then 3).
- Throughput: one operation per latency + 1 cycle minimum. IDLE lasts at least one cycle between operations.
- result and out_valid are registered; no combinational path from inputs to them.
- in_ready is combinational from state and flush only.
- Async reset assertion clears outputs immediately, without waiting for a clock edge.
- Deassertion is synchronised externally; the first edge after release may accept.

## Test plan
- STEP=1, SLL, a=0x00000001, shamt=31 -> result 0x80000000; out_valid rises 32 edges after accept; busy high throughout.
- a=0x80000000, shamt=4:
  - SRA -> 0xF8000000.
  - SRL -> 0x08000000.
  - SLL -> 0x00000000.
- ROTR, a=0x000000F1, shamt=4 -> 0x1000000F.
- ROTR, shamt=0, a=0xDEADBEEF -> 0xDEADBEEF one edge after accept.
- STEP=4, SRA, a=0xF0000000, shamt=7 -> 0xFFE00000 after 3 edges.
- Backpressure: hold out_ready low 5 cycles in DONE while driving in_valid=1 with new operands.
  - result and out_valid stay constant; in_ready=0; no accept.
  - Raise out_ready: IDLE next cycle; the pending in_valid is accepted on the following edge.
- Abort, STEP=1, SLL shamt=20:
  - Assert flush 5 cycles after accept: IDLE next edge, out_valid never rises, in_ready returns to 1.
  - Repeat with rst_n pulsed low mid-SHIFT: outputs clear asynchronously (result 0, busy 0).
